// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// slave: loader side; master: host byte source plus memory/CPU side.
//   start, byte_in[7:0], byte_valid        host -> loader
//   byte_ready                             loader -> host
//   mem_we, mem_addr[31:0], mem_wdata[31:0] loader -> imem write port
//   cpu_hold, done, error, words_loaded[15:0] loader -> CPU/status
interface imem_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    modport master (
        output start,
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_hold,
        input  done,
        input  error,
        input  words_loaded
    );

    modport slave (
        input  start,
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_hold,
        output done,
        output error,
        output words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: length-prefixed big-endian byte stream to
// consecutive word writes; holds the CPU in reset until the load completes.
//   i_clk   rising-edge clock
//   i_rst   asynchronous reset, active low
//   io_bus  imem_loader_if.slave (stream in, imem write port, status out)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    imem_loader_if.slave  io_bus
);

    localparam logic [16:0] LP_DEPTH = 17'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [31:0] r_word;
    logic [1:0]  r_bcnt;
    logic [15:0] r_words;

    logic        w_ready;
    logic        w_we;
    logic        w_hold;
    logic        w_done;
    logic        w_err;
    logic        w_xfer;
    logic        w_last;
    logic [15:0] w_len;

    assign w_xfer = io_bus.byte_valid & w_ready;
    // Full length as it stands during the LEN_LO transfer.
    assign w_len  = {r_len[15:8], io_bus.byte_in};
    assign w_last = (r_words + 16'd1) == r_len;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (io_bus.start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)
                        w_next = S_DONE;
                    else if ({1'b0, w_len} > LP_DEPTH)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && r_bcnt == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = w_last ? S_DONE : S_DATA;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_hold  = 1'b1;
        w_done  = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA: w_ready = 1'b1;
            S_WRITE: w_we = 1'b1;
            S_DONE: begin
                w_hold = 1'b0;
                w_done = 1'b1;
            end
            S_ERR: w_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_len   <= '0;
            r_word  <= '0;
            r_bcnt  <= '0;
            r_words <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (io_bus.start) begin
                        r_words <= '0;
                        r_bcnt  <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) r_len[15:8] <= io_bus.byte_in;
                end
                S_LEN_LO: begin
                    if (w_xfer) r_len[7:0] <= io_bus.byte_in;
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_word <= {r_word[23:0], io_bus.byte_in};
                        // Wraps to 0 on the 4th byte, ready for the next word.
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_words <= r_words + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.byte_ready   = w_ready;
    assign io_bus.mem_we       = w_we;
    assign io_bus.mem_addr     = BASE_ADDR + {14'd0, r_words, 2'b00};
    assign io_bus.mem_wdata    = r_word;
    assign io_bus.cpu_hold     = w_hold;
    assign io_bus.done         = w_done;
    assign io_bus.error        = w_err;
    assign io_bus.words_loaded = r_words;

endmodule
